icache_responder: RTL and testbench

- Instruction-side responder that sits between the PC/fetch stage and instruction memory.
- Accepts the fetch stage's address/valid request and returns the instruction word, with a busy indication on the same interface.
- Backed by a direct-mapped, one-word-per-line cache; misses are refilled through a simple req/ready memory port.
- The fetch stage stalls its PC while out_busy is high and consumes out_inst when out_busy is low.

---
 rtl/icache_responder.sv | 114 +++++++++++
 tb/tb_icache_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage and
// instruction memory. Hits answer in the same cycle; misses refill over a req/ready port.
module icache_responder #(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic [31:0] out_inst,
  output logic        out_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t state, next_state;

  logic [31:0]       data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_bits;

  // Word address of the outstanding refill; byte offset is always zero.
  logic [29:0]       fetch_word;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  start_fetch;
  logic                  fill;
  logic                  addr_lsb_unused;

  assign req_idx         = req_addr[INDEX_BITS+1:2];
  assign req_tag         = req_addr[31:INDEX_BITS+2];
  assign fill_idx        = fetch_word[INDEX_BITS-1:0];
  assign fill_tag        = fetch_word[29:INDEX_BITS];
  assign addr_lsb_unused = ^req_addr[1:0];

  // Hits are only honoured in IDLE so a refill in flight always finishes first.
  assign hit      = (state == IDLE) && valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);
  assign out_busy = req_valid && !hit;
  assign out_inst = (req_valid && hit) ? data_mem[req_idx] : NOP_INST;
  assign mem_req  = (state == FETCH);
  assign mem_addr = {fetch_word, 2'b00};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    fill        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !hit) begin
          start_fetch = 1'b1;
          next_state  = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_word <= '0;
    end else if (start_fetch) begin
      fetch_word <= req_addr[31:2];
    end
  end

  // Flush beats a coincident fill: the line is written but left invalid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_bits <= '0;
    end else if (flush) begin
      valid_bits <= '0;
    end else if (fill) begin
      valid_bits[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      data_mem[fill_idx] <= mem_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: hand-sequenced fetches with a bench-driven memory.
module tb_icache_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic [31:0] out_inst;
  logic        out_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int vectors    = 0;
  int miscompares = 0;

  icache_responder #(.INDEX_BITS(6), .NOP_INST(NOP)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .flush     (flush),
    .out_inst  (out_inst),
    .out_busy  (out_busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic fl);
    req_valid = valid;
    req_addr  = addr;
    flush     = fl;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0);
    checkOutput("hit_busy", out_busy, 0);
    checkOutput("hit_inst", out_inst, data);
    checkOutput("hit_memreq", mem_req, 0);
  endtask

  // Presents a missing address in IDLE and advances into FETCH.
  task automatic expect_miss(input logic [31:0] addr);
    applyStimulus(1'b1, addr, 1'b0);
    checkOutput("miss_busy", out_busy, 1);
    checkOutput("miss_inst", out_inst, NOP);
    step();
  endtask

  // Acts as memory: answers on the lat-th FETCH cycle, optionally flushing on that cycle.
  task automatic serve_refill(input logic [31:0] exp_addr, input logic [31:0] data,
                              input int lat, input logic flush_at_ready);
    for (int i = 1; i <= lat; i++) begin
      checkOutput("refill_req", mem_req, 1);
      checkOutput("refill_addr", mem_addr, exp_addr);
      if (i == lat) begin
        mem_ready = 1'b1;
        mem_rdata = data;
        flush     = flush_at_ready;
        #1;
      end
      checkOutput("refill_busy", out_busy, 1);
      step();
      mem_ready = 1'b0;
      flush     = 1'b0;
    end
    checkOutput("refill_done_req", mem_req, 0);
  endtask

  initial begin
    RST_N     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    #12;
    checkOutput("rst_memreq", mem_req, 0);
    checkOutput("rst_memaddr", mem_addr, 32'h0);
    checkOutput("rst_busy", out_busy, 0);
    checkOutput("rst_inst", out_inst, NOP);
    RST_N = 1'b1;
    step();

    // Cold miss on 0x0 with three-cycle memory, then same-cycle hit.
    expect_miss(32'h0);
    serve_refill(32'h0, 32'h00500093, 3, 1'b0);
    expect_hit(32'h0, 32'h00500093);

    // Idle request, stray mem_ready in IDLE must not disturb the line.
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("idle_busy", out_busy, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("idle_ready_memreq", mem_req, 0);
    step();
    mem_ready = 1'b0;
    expect_hit(32'h0, 32'h00500093);

    // 0x100 shares index 0 with 0x0: mutual eviction.
    expect_miss(32'h100);
    serve_refill(32'h100, 32'hAAAA0100, 1, 1'b0);
    expect_hit(32'h100, 32'hAAAA0100);
    expect_miss(32'h0);
    serve_refill(32'h0, 32'h00500093, 2, 1'b0);
    expect_hit(32'h0, 32'h00500093);

    // Address changes mid-FETCH: 0x4 refill completes, then 0x8 is fetched.
    expect_miss(32'h4);
    applyStimulus(1'b1, 32'h8, 1'b0);
    checkOutput("redirect_busy", out_busy, 1);
    serve_refill(32'h4, 32'h11110004, 2, 1'b0);
    checkOutput("redirect_miss_busy", out_busy, 1);
    step();
    serve_refill(32'h8, 32'h22220008, 1, 1'b0);
    expect_hit(32'h8, 32'h22220008);
    expect_hit(32'h4, 32'h11110004);

    // Flush on a hitting cycle: hit now, miss afterwards.
    applyStimulus(1'b1, 32'h0, 1'b1);
    checkOutput("flush_cycle_busy", out_busy, 0);
    checkOutput("flush_cycle_inst", out_inst, 32'h00500093);
    step();
    expect_miss(32'h0);
    serve_refill(32'h0, 32'h00500093, 1, 1'b0);
    expect_hit(32'h0, 32'h00500093);

    // Flush coincident with mem_ready leaves 0xC invalid.
    expect_miss(32'hC);
    serve_refill(32'hC, 32'h3333000C, 2, 1'b1);
    expect_miss(32'hC);
    serve_refill(32'hC, 32'h4444000C, 1, 1'b0);
    expect_hit(32'hC, 32'h4444000C);

    // Reset in the middle of a 0x10 refill.
    expect_miss(32'h10);
    checkOutput("prerst_memreq", mem_req, 1);
    RST_N = 1'b0;
    #1;
    checkOutput("midrst_memreq", mem_req, 0);
    checkOutput("midrst_memaddr", mem_addr, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD00010;
    step();
    mem_ready = 1'b0;
    RST_N     = 1'b1;
    expect_miss(32'h10);
    serve_refill(32'h10, 32'h55550010, 2, 1'b0);
    expect_hit(32'h10, 32'h55550010);

    applyStimulus(1'b0, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
